uart_rx_frame: RTL

- Serial-to-parallel UART receiver.
- Deframes 8N1/8E1/8O1 frames arriving on a single line, oversampled at 8x, 16x or 32x.
- Emits each byte as a parallel word with a single-cycle valid pulse.
- Sits directly upstream of the system controller and drives its received-data and received-data-valid inputs.

---
 rtl/uart_rx_frame_if.sv | 26 ++
 rtl/uart_rx_frame.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line, frame configuration and received-byte
// outputs of the UART frame receiver, bundled as one port.
// The receiver connects to the slave modport. The driving side (line,
// configuration and result consumer) connects to the master modport.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver for 8N1 / 8E1 / 8O1 frames.
// Every bit is decided by a 2-of-3 majority vote around mid-bit.
// The oversampling ratio is 8, 16 or 32, and any other value runs as 8.
// A good frame loads P_DATA and pulses data_valid one cycle after the
// last edge of the stop bit. A bad frame pulses par_err and/or stp_err.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, PAR_EN and
// PAR_TYP select a parity bit. When it is undefined, frames are always 8N1
// and par_err is held at 0.
module uart_rx_frame (
  input  logic             CLK,
  input  logic             RST,
  uart_rx_frame_if.slave   bus
);
  localparam int DW = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Expected parity bit: XOR of the data bits, inverted for odd parity.
  function automatic logic parity_bit(input logic [DW-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t          state_q;
  logic [1:0]      sync_q;
  logic [5:0]      pre_q;
  logic [5:0]      edge_q;
  logic [2:0]      bit_q;
  logic [2:0]      samp_q;
  logic [DW-1:0]   shift_q;
  logic [DW-1:0]   data_q;
  logic            valid_q;
  logic            stp_err_q;
`ifdef UART_RX_PARITY_EN
  logic            par_en_q;
  logic            par_typ_q;
  logic            par_bad_q;
  logic            par_err_q;
`else
  logic            unused_par_s;
`endif

  logic            rx_s;
  logic [5:0]      pre_sel;
  logic [5:0]      half;
  logic            last_edge;
  logic            maj_bit;

  assign rx_s = sync_q[1];

  // Helper decodes: effective prescale, mid-bit point, end-of-bit flag and majority vote.
  always_comb begin
    if ((bus.Prescale == 6'd16) || (bus.Prescale == 6'd32)) begin
      pre_sel = bus.Prescale;
    end else begin
      pre_sel = 6'd8;
    end
    half      = pre_q >> 1;
    last_edge = (edge_q == (pre_q - 6'd1));
    maj_bit   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  end

  // Two-flop synchronizer for the asynchronous serial line. It resets to the idle level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.RX_IN};
    end
  end

  // Frame FSM: bit timing, mid-bit sampling, deserialisation and registered result pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      pre_q     <= 6'd8;
      edge_q    <= 6'd0;
      bit_q     <= 3'd0;
      samp_q    <= 3'b111;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      stp_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      valid_q   <= 1'b0;
      stp_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
      // Bit timing and the three mid-bit samples, common to every non-idle state.
      if (state_q != IDLE) begin
        edge_q <= last_edge ? 6'd0 : edge_q + 6'd1;
        if (edge_q == half - 6'd1) samp_q[0] <= rx_s;
        if (edge_q == half)        samp_q[1] <= rx_s;
        if (edge_q == half + 6'd1) samp_q[2] <= rx_s;
      end

      case (state_q)
        IDLE: begin
          edge_q <= 6'd0;
          // This cycle is edge 0 of the start bit, so counting resumes at 1.
          if (!rx_s) begin
            state_q   <= START;
            edge_q    <= 6'd1;
            pre_q     <= pre_sel;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
`endif
          end
        end
        START: begin
          if (last_edge) begin
            if (!maj_bit) begin
              state_q   <= DATA;
              bit_q     <= 3'd0;
`ifdef UART_RX_PARITY_EN
              par_bad_q <= 1'b0;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (last_edge) begin
            shift_q <= {maj_bit, shift_q[DW-1:1]};
            if (bit_q == 3'(DW - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= par_en_q ? PARITY : STOP;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (last_edge) begin
            par_bad_q <= (maj_bit != parity_bit(shift_q, par_typ_q));
            state_q   <= STOP;
          end
        end
`endif
        STOP: begin
          if (last_edge) begin
            stp_err_q <= ~maj_bit;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_bad_q;
            valid_q   <= maj_bit & ~par_bad_q;
            if (maj_bit && !par_bad_q) data_q <= shift_q;
`else
            valid_q   <= maj_bit;
            if (maj_bit) data_q <= shift_q;
`endif
            // A low line already at the last stop edge is taken as the next start bit's edge 0.
            if (!rx_s) begin
              state_q   <= START;
              edge_q    <= 6'd1;
              pre_q     <= pre_sel;
`ifdef UART_RX_PARITY_EN
              par_en_q  <= bus.PAR_EN;
              par_typ_q <= bus.PAR_TYP;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.P_DATA     = data_q;
  assign bus.data_valid = valid_q;
  assign bus.stp_err    = stp_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.par_err    = par_err_q;
`else
  assign bus.par_err    = 1'b0;
  assign unused_par_s   = bus.PAR_EN ^ bus.PAR_TYP ^ parity_bit(shift_q, 1'b0);
`endif
endmodule
